// File: rtl/mem_line_initiator_pkg.sv
// Shared types for the cache-line initiator: address/MESI types, FSM states
// and the line-alignment helper.
package mem_line_initiator_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int INDEX_W        = 9;
  localparam int PAGE_W         = 16;

  typedef enum logic [1:0] {
    INV = 2'b00,
    SHR = 2'b01,
    EXC = 2'b10,
    MOD = 2'b11
  } Tmesi_state;

  typedef struct packed {
    logic [PAGE_W-1:0]  Page_reference;
    logic [INDEX_W-1:0] Index;
  } Taddress;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } Tline_req_state;

  // Clears the word-offset bits so every beat of the line stays inside one
  // aligned block; the offset is later ORed back in with no carry.
  function automatic logic [INDEX_W-1:0] line_base(input logic [INDEX_W-1:0] idx,
                                                   input int unsigned        words);
    return idx & ~INDEX_W'(words - 1);
  endfunction

endpackage

// File: rtl/mem_line_initiator_rd_tag_pipe.sv
// Tags each issued read beat with its word offset and delays it by the
// memory read latency so the tag emerges alongside mem_rdata.
module mem_rd_tag_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][IDX_W-1:0] idx_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld && !flush;
      idx_pipe[0] <= in_idx;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1] && !flush;
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  assign out_vld = vld_pipe[LAT-1];
  assign out_idx = idx_pipe[LAT-1];

endmodule

// File: rtl/mem_line_initiator.sv
// Sequences one cache-line fill or writeback into LINE_WORDS single-word
// MainMemory accesses, returning read words beat by beat plus a done pulse.
module mem_line_initiator
  import mem_line_initiator_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int MEM_RD_LAT = 1,
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  Taddress                    req_addr,
  input  logic [LINE_WORDS*32-1:0]   req_wline,
  input  Tmesi_state                 req_mesi,
  output logic                       beat_valid,
  output logic [OFF_W-1:0]           beat_idx,
  output logic [31:0]                beat_data,
  output logic                       done_valid,
  output Tmesi_state                 done_mesi,
  output logic                       done_page_hit,
  output Taddress                    mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       mem_we,
  output Tmesi_state                 mem_mesi_in,
  input  logic [31:0]                mem_rdata,
  input  Tmesi_state                 mem_mesi_out,
  input  logic [PAGE_W-1:0]          mem_page_ref
);

  localparam logic [OFF_W-1:0] LAST_B = OFF_W'(LINE_WORDS - 1);

  Tline_req_state state, state_nxt;

  logic [OFF_W-1:0]                 b;
  logic [PAGE_W-1:0]                page_q;
  logic [INDEX_W-1:0]               base_q;
  logic [LINE_WORDS-1:0][31:0]      wline_q;
  Tmesi_state                       mesi_q;

  logic             hs;
  logic             last_b;
  logic             last_beat;
  logic             issue_rd;
  logic             tag_vld;
  logic [OFF_W-1:0] tag_idx;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign req_ready = reset && (state == IDLE);
  assign hs        = req_valid && req_ready;
  assign last_b    = (b == LAST_B);
  assign last_beat = beat_valid && (beat_idx == LAST_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_we     = 1'b0;
    issue_rd   = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE:     if (hs) state_nxt = req_write ? WR_ISSUE : RD_ISSUE;
      WR_ISSUE: begin
        mem_we = 1'b1;
        if (last_b) state_nxt = DONE;
      end
      RD_ISSUE: begin
        issue_rd = 1'b1;
        if (last_b) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: if (last_beat) state_nxt = DONE;
      DONE: begin
        done_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Request capture and beat counter; b parks on the last word so the drain
  // phase keeps presenting the final address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b       <= '0;
      page_q  <= '0;
      base_q  <= '0;
      wline_q <= '0;
      mesi_q  <= INV;
    end else if (hs) begin
      b       <= '0;
      page_q  <= req_addr.Page_reference;
      base_q  <= line_base(req_addr.Index, LINE_WORDS);
      wline_q <= req_wline;
      mesi_q  <= req_mesi;
    end else if ((state == WR_ISSUE || state == RD_ISSUE) && !last_b) begin
      b <= b + OFF_W'(1);
    end
  end

  assign mem_addr    = {page_q, base_q | INDEX_W'(b)};
  assign mem_wdata   = wline_q[b];
  assign mem_mesi_in = mesi_q;

  mem_rd_tag_pipe #(
    .LAT   (MEM_RD_LAT),
    .IDX_W (OFF_W)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (state == IDLE),
    .in_vld  (issue_rd),
    .in_idx  (b),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  // Return stage: register the word the emerging tag belongs to; the last
  // tag also snapshots the line state and page compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_valid    <= 1'b0;
      beat_idx      <= '0;
      beat_data     <= '0;
      done_mesi     <= INV;
      done_page_hit <= 1'b0;
    end else begin
      beat_valid <= tag_vld;
      if (tag_vld) begin
        beat_idx  <= tag_idx;
        beat_data <= mem_rdata;
      end
      if (hs) begin
        done_mesi     <= INV;
        done_page_hit <= 1'b0;
      end else if (tag_vld && tag_idx == LAST_B) begin
        done_mesi     <= mem_mesi_out;
        done_page_hit <= (mem_page_ref == page_q);
      end
    end
  end

endmodule

// File: doc/mem_line_initiator.md
Name: mem_line_initiator

Overview:
- Memory-side initiator between a cache controller and MainMemory.
- Accepts one line-sized request (fill read or writeback) from the cache and sequences it into LINE_WORDS single-word accesses on the MainMemory port: addr, wdata, we, mesi_state_in, rdata, mesi_state_out, Page_reference_out.
- Returns read words beat by beat, then a completion pulse.

Parameters:
- LINE_WORDS, 4, words per line; power of two, 2..16, divides 512.
- MEM_RD_LAT, 1, cycles from addr presented to rdata valid at MainMemory; 1..4.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  cache request valid.
- req_ready  out  1  initiator idle and accepting.
- req_write  in  1  1 = writeback line, 0 = fill read.
- req_addr  in  Taddress  Page_reference[15:0] and Index[8:0]; Index low bits are ignored (line-aligned).
- req_wline  in  LINE_WORDS*32  writeback data; word k is bits [32k+31:32k].
- req_mesi  in  Tmesi_state  state written with each writeback word.
- beat_valid  out  1  one read word is valid this cycle; no backpressure.
- beat_idx  out  $clog2(LINE_WORDS)  word offset of beat_valid data.
- beat_data  out  32  read word.
- done_valid  out  1  one-cycle completion pulse.
- done_mesi  out  Tmesi_state  mesi_state_out sampled with the last read beat; INV for writes.
- done_page_hit  out  1  Page_reference_out == request page, sampled with the last beat (reads only; 0 for writes).
- mem_addr  out  Taddress  to MainMemory addr.
- mem_wdata  out  32  to MainMemory wdata.
- mem_we  out  1  to MainMemory we.
- mem_mesi_in  out  Tmesi_state  to MainMemory mesi_state_in.
- mem_rdata  in  32  from MainMemory rdata.
- mem_mesi_out  in  Tmesi_state  from MainMemory mesi_state_out.
- mem_page_ref  in  16  from MainMemory Page_reference_out.

Behaviour:
- Reset values while reset=0:
  - req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_mesi_in=INV.
  - beat_valid=0, done_valid=0, done_mesi=INV, done_page_hit=0, FSM=IDLE.
  - The first cycle after deassertion shows req_ready=1.
- Request capture:
  - Handshake on posedge with req_valid&&req_ready.
  - Captured: write flag, page, base = Index with low log2(LINE_WORDS) bits cleared, wline, mesi.
  - req_ready=1 only in IDLE. There is no queueing, and inputs are ignored outside IDLE.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_DRAIN, DONE.
- IDLE: on handshake go to WR_ISSUE (write) or RD_ISSUE (read).
- WR_ISSUE, beat counter b=0..LINE_WORDS-1, one word per cycle:
  - mem_we=1, mem_addr={page, base+b}, mem_wdata=wline word b, mem_mesi_in=req_mesi.
  - After b=LINE_WORDS-1, go to DONE with mem_we=0.
  - Writes take LINE_WORDS cycles.
- RD_ISSUE: mem_we=0 and mem_addr={page, base+b} for b=0..LINE_WORDS-1, one per cycle.
- Read return pipeline:
  - A MEM_RD_LAT-deep shift register tags each issued beat.
  - When a tag emerges: beat_valid=1, beat_idx=tag, beat_data=mem_rdata, registered one cycle after mem_rdata is valid.
  - The first beat_valid occurs MEM_RD_LAT+1 cycles after the first issue cycle.
- RD_DRAIN: entered after the last issue; holds mem_addr at the last address until all LINE_WORDS beats are returned.
- Last beat: sample mem_mesi_out into done_mesi and (mem_page_ref==page) into done_page_hit, then go to DONE.
- DONE: done_valid=1 for exactly one cycle, then IDLE.
  - done_valid never coincides with beat_valid; the last beat precedes done by 1 cycle.
  - Minimum gap between handshakes: writes LINE_WORDS+2 cycles, reads LINE_WORDS+MEM_RD_LAT+3 cycles.
- Index arithmetic: base+b never exceeds 511, because the line is aligned and LINE_WORDS divides 512. Offset add uses log2(LINE_WORDS)-bit OR into the base, with no carry into Page_reference.
- Beat order is always 0..LINE_WORDS-1 (no critical-word-first).
- Reset mid-operation:
  - mem_we and all valids drop asynchronously and in-flight tags are flushed.
  - No done_valid is issued for the aborted request, and the cache must reissue it.
- req_valid held high in DONE is not accepted until the following IDLE cycle.

Decomposition:
- definesPkg gets:
  - Tline_req_state enum {IDLE, WR_ISSUE, RD_ISSUE, RD_DRAIN, DONE}.
  - LINE_WORDS_DEF=4 and INDEX_W=9.
  - It reuses Taddress and Tmesi_state.
- One sub-module, mem_rd_tag_pipe: a MEM_RD_LAT-deep valid+idx shift register with flush.

Test Plan:
- Fill read, req_addr={16'hBEEF, 9'h013}, memory preloaded with word i = 32'hA000_0000+i:
  - Addresses issued are 0x010..0x013.
  - beats 0..3 carry A0000010..A0000013.
  - done_valid follows 1 cycle after beat 3, with done_page_hit=1 when mem_page_ref=BEEF.
- Writeback at Index 9'h1FC, wline={4'h…}=words 11111111/22222222/33333333/44444444, req_mesi=MOD:
  - mem_we is high for exactly 4 cycles at 0x1FC..0x1FF with matching wdata and mesi_in=MOD.
  - No wrap into 0x000; done_valid follows.
- Back-to-back, req_valid held high:
  - req_ready=0 from the handshake until the cycle after done_valid.
  - The second request is accepted exactly then; the measured gap is 6 cycles (write) or 8 cycles (read, MEM_RD_LAT=1).
- MEM_RD_LAT=3 build:
  - The first beat_valid comes 4 cycles after the first issue.
  - All 4 beats are in order, and there is no beat after done.
- Reset asserted (reset=0) during the third read issue cycle:
  - mem_we=0 and beat_valid=0 immediately, with no done_valid.
  - After release, req_ready=1 on the next cycle and a new read completes correctly.
- Page mismatch: mem_page_ref=16'h0001 vs request 16'h0002 -> done_page_hit=0; done_mesi equals the mem_mesi_out value (e.g. SHR) driven on the last beat.
